vending_machine_change: RTL
===========================

VENDING_MACHINE_CHANGE -- requirements
Module: vending_machine_change

Interface
REQ-001 SHALL provide parameter PRICE_N, default 3, meaning item price in nickel units (3 = 15 cents); legal range 1..31.
REQ-002 SHALL provide parameter CREDIT_W, default 6, meaning width of the credit register in nickel units; it SHALL hold at least PRICE_N+4, and elaboration SHALL fail otherwise.
REQ-003 SHALL provide port clk, input, 1, meaning the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL provide port rst, input, 1, meaning reset, synchronous and active-high.
REQ-005 SHALL provide port nickel, input, 1, meaning a 5-cent coin is presented this cycle (1 unit).
REQ-006 SHALL provide port dime, input, 1, meaning a 10-cent coin is presented this cycle (2 units).
REQ-007 SHALL provide port quarter, input, 1, meaning a 25-cent coin is presented this cycle (5 units).
REQ-008 SHALL provide port cancel, input, 1, meaning a refund of all current credit is requested.
REQ-009 SHALL provide port chg_ready, input, 1, meaning the coin hopper accepts one returned nickel this cycle.
REQ-010 SHALL provide port open, output, 1, meaning vend strobe; it is registered and lasts exactly one cycle.
REQ-011 SHALL provide port chg_valid, output, 1, meaning the block offers one nickel of change or refund.
REQ-012 SHALL provide port coin_reject, output, 1, meaning a presented coin was not accepted; it is a registered one-cycle pulse.
REQ-013 SHALL provide port busy, output, 1, meaning the block is in VEND or CHANGE.
REQ-014 SHALL provide port credit, output, CREDIT_W, meaning the current credit in nickel units, taken directly from the register.

Function
REQ-015 SHALL implement states IDLE (credit 0), ACCUM (0 < credit < PRICE_N), VEND and CHANGE.
REQ-016 In IDLE/ACCUM, when exactly one coin input is high at edge k, SHALL take sum = credit + coin value, and the result SHALL be visible after edge k.
REQ-017 If sum < PRICE_N, SHALL set credit = sum and state = ACCUM.
REQ-018 If sum >= PRICE_N, SHALL set credit = sum - PRICE_N and state = VEND, with open high during the cycle after edge k.
REQ-019 In IDLE/ACCUM with no coin, SHALL hold credit and state.
REQ-020 When two or more coin inputs are high in the same cycle, SHALL accept none of them, pulse coin_reject for one cycle and leave credit unchanged.
REQ-021 SHALL remain in VEND for exactly one cycle, then go to CHANGE if credit > 0, else to IDLE.
REQ-022 In CHANGE, SHALL hold chg_valid = (credit > 0).
REQ-023 In CHANGE, on each edge with chg_valid && chg_ready, SHALL decrement credit by 1; at credit 0 the state SHALL go to IDLE in the same edge.
REQ-024 SHALL hold chg_valid stable high until it is accepted, with no decrement while chg_ready is low, and SHALL hold chg_valid low outside CHANGE.
REQ-025 On cancel in ACCUM, SHALL go to CHANGE with credit unchanged and SHALL NOT assert open.
REQ-026 SHALL ignore cancel in IDLE, VEND and CHANGE.
REQ-027 When cancel and a coin occur in the same ACCUM cycle, cancel SHALL win: the coin is rejected (coin_reject pulse) and the refund covers the prior credit only.
REQ-028 When cancel and a coin occur in the same IDLE cycle, SHALL accept the coin normally.
REQ-029 SHALL reject any coin presented in VEND or CHANGE with a coin_reject pulse and no credit change.
REQ-030 SHALL assert busy combinationally from the state register: 1 in VEND/CHANGE, 0 in IDLE/ACCUM.
REQ-031 SHALL never let credit wrap or exceed PRICE_N+4.
REQ-032 SHALL treat an unreachable state encoding as IDLE with credit 0 on the next edge.

Reset
REQ-033 At the edge where rst=1, SHALL set state=IDLE, credit=0, open=0, chg_valid=0, coin_reject=0 and busy=0.
REQ-034 Reset SHALL override every input in the same edge, including mid-VEND and mid-CHANGE; pending change is discarded.
REQ-035 SHALL ignore coins presented in the reset cycle and SHALL NOT report them via coin_reject.

Verification
REQ-036 PRICE_N=3: nickel, nickel, nickel on consecutive cycles -> credit 1, 2, then open pulse of 1 cycle, credit 0, IDLE, chg_valid never high.
REQ-037 PRICE_N=3, chg_ready=1: quarter -> open 1 cycle, credit 2, then chg_valid 2 cycles, credit 1, 0, IDLE.
REQ-038 PRICE_N=3: dime, then cancel with nickel in the same cycle -> coin_reject 1 cycle, no open, 2 nickels refunded, IDLE.
REQ-039 dime+nickel in the same cycle -> coin_reject 1 cycle, credit stays 0; a later dime during CHANGE -> coin_reject, credit unaffected.
REQ-040 PRICE_N=3, quarter with chg_ready held low 4 cycles -> chg_valid stays high, credit stays 2 and busy=1 for those 4 cycles; chg_ready then high -> 2 nickels, IDLE.
REQ-041 PRICE_N=7, CREDIT_W=4: quarter, quarter -> credit 5, then open, credit 3, 3 nickels of change; rst asserted after the first nickel -> next cycle credit 0, chg_valid 0, IDLE.

Source files
------------

// File: rtl/vending_machine_change.sv
// Coin-accepting vending controller: accumulates nickel-unit credit, vends at PRICE_N
// and pays change or refunds one nickel at a time through a valid/ready hopper port.
module vending_machine_change #(
  parameter int PRICE_N  = 3,
  parameter int CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                cancel,
  input  logic                chg_ready,
  output logic                open,
  output logic                chg_valid,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam int SW = CREDIT_W + 1;
  localparam logic [SW-1:0] PRICE_S = SW'(PRICE_N);

  if (PRICE_N < 1 || PRICE_N > 31) begin : g_bad_price
    $error("PRICE_N must lie in 1..31");
  end
  if (((1 << CREDIT_W) - 1) < (PRICE_N + 4)) begin : g_bad_credit_w
    $error("CREDIT_W too narrow to hold PRICE_N+4");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic                open_nxt, reject_nxt;
  logic                any_coin, multi_coin;
  logic [SW-1:0]       sum;

  // Value of a single presented coin; zero unless exactly one coin is high.
  function automatic logic [2:0] coin_units(input logic n, input logic d, input logic q);
    logic [2:0] u;
    u = 3'd0;
    if (n && !d && !q) u = 3'd1;
    if (d && !n && !q) u = 3'd2;
    if (q && !n && !d) u = 3'd5;
    return u;
  endfunction

  assign any_coin   = nickel | dime | quarter;
  assign multi_coin = (nickel & dime) | (nickel & quarter) | (dime & quarter);
  assign sum        = {1'b0, credit} + SW'(coin_units(nickel, dime, quarter));

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    open_nxt   = 1'b0;
    reject_nxt = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        // Cancel only matters with credit on hand; it then beats any coin.
        if (state == ACCUM && cancel) begin
          state_nxt  = CHANGE;
          reject_nxt = any_coin;
        end else if (multi_coin) begin
          reject_nxt = 1'b1;
        end else if (any_coin) begin
          if (sum >= PRICE_S) begin
            credit_nxt = CREDIT_W'(sum - PRICE_S);
            state_nxt  = VEND;
            open_nxt   = 1'b1;
          end else begin
            credit_nxt = sum[CREDIT_W-1:0];
            state_nxt  = ACCUM;
          end
        end
      end
      VEND: begin
        reject_nxt = any_coin;
        state_nxt  = (credit != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_nxt = any_coin;
        if (credit == '0) begin
          state_nxt = IDLE;
        end else if (chg_ready) begin
          credit_nxt = credit - CREDIT_W'(1);
          if (credit == CREDIT_W'(1)) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        credit_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= '0;
      open        <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      open        <= open_nxt;
      coin_reject <= reject_nxt;
    end
  end

  assign chg_valid = (state == CHANGE) && (credit != '0);
  assign busy      = (state == VEND) || (state == CHANGE);

endmodule
